// File: rtl/occ_grid_mem.sv
// Packed single-bit occupancy map with a hardware clear sweep, bounds-checked
// registered reads and a live count of occupied cells.
module occ_grid_mem #(
  parameter int unsigned MAP_W = 1024,
  parameter int unsigned MAP_H = 1024,
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned LANES = 32,
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_start,
  output logic             busy,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic             wr_data,
  input  logic             rd_req,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic             rd_data,
  output logic             rd_oob,
  output logic [CNT_W-1:0] occ_count
);

  localparam int unsigned DEPTH = MAP_W * MAP_H / LANES;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WPR   = MAP_W / LANES;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  logic [LANES-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic             busy_d, rd_valid_d, rd_data_d, rd_oob_d;
  logic [CNT_W-1:0] occ_d;
  logic             wr_acc, rd_acc;

  // Coordinate decode: word = y*WPR + x/LANES, bit = x mod LANES
  logic          wr_in, rd_in;
  logic [AW-1:0] wr_word, rd_word;
  logic [BW-1:0] wr_bit, rd_bit;
  logic          old_bit, rd_stored;

  assign wr_in     = (32'(wr_x) < MAP_W) && (32'(wr_y) < MAP_H);
  assign rd_in     = (32'(rd_x) < MAP_W) && (32'(rd_y) < MAP_H);
  assign wr_word   = AW'(32'(wr_y) * WPR + 32'(wr_x) / LANES);
  assign rd_word   = AW'(32'(rd_y) * WPR + 32'(rd_x) / LANES);
  assign wr_bit    = BW'(32'(wr_x) % LANES);
  assign rd_bit    = BW'(32'(rd_x) % LANES);
  assign old_bit   = mem[wr_word][wr_bit];
  assign rd_stored = mem[rd_word][rd_bit];

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data;
    rd_oob_d   = rd_oob;
    occ_d      = occ_count;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;

    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + AW'(1);
      if (clr_addr_q == AW'(DEPTH - 1)) begin
        state_d    = IDLE;
        clr_addr_d = '0;
      end
    end else begin
      rd_acc = rd_req;
      if (clear_start) begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end else begin
        wr_acc = wr_en && wr_in;
      end
    end

    // Write-first forwarding only for the exact same cell
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      rd_oob_d   = !rd_in;
      if (!rd_in)
        rd_data_d = 1'b1;
      else if (wr_acc && (wr_word == rd_word) && (wr_bit == rd_bit))
        rd_data_d = wr_data;
      else
        rd_data_d = rd_stored;
    end

    if (wr_acc && (old_bit != wr_data))
      occ_d = wr_data ? occ_count + CNT_W'(1) : occ_count - CNT_W'(1);
    if ((state_q == IDLE) && clear_start)
      occ_d = '0;

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy       <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= 1'b0;
      rd_oob     <= 1'b0;
      occ_count  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy       <= busy_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
      rd_oob     <= rd_oob_d;
      occ_count  <= occ_d;
    end
  end

  // Storage is not reset; the sweep zeroes it word by word
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_addr_q] <= '0;
    else if (wr_acc)
      mem[wr_word][wr_bit] <= wr_data;
  end

endmodule

// File: tb/tb_occ_grid_mem.sv
// Scoreboard bench for occ_grid_mem on a 64x16 map of 8-cell words; coordinate
// widths are one bit wider than strictly needed so out-of-map reads are reachable.
module tb_occ_grid_mem;
  localparam int unsigned MW = 64, MH = 16, LN = 8, XW = 7, YW = 5, CW = 11;
  localparam int unsigned DEPTH = MW * MH / LN;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          clear_start, busy, wr_en, wr_data, rd_req;
  logic          rd_valid, rd_data, rd_oob;
  logic [XW-1:0] wr_x, rd_x;
  logic [YW-1:0] wr_y, rd_y;
  logic [CW-1:0] occ_count;

  occ_grid_mem #(.MAP_W(MW), .MAP_H(MH), .X_W(XW), .Y_W(YW), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_oob(rd_oob), .occ_count(occ_count)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {logic d; logic oob; int at;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endfunction

  // Monitor: every rd_valid must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 required no pending read");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rd_data", int'(rd_data), int'(e.d));
        check("rd_oob", int'(rd_oob), int'(e.oob));
        check("rd_latency_cycle", cyc_n, e.at);
      end
    end
    if (int'(occ_count) > int'(MW * MH)) begin
      n_bad++;
      $display("FAIL occ_count_range: got %0d required <= %0d", occ_count, MW * MH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_req = 1'b0; clear_start = 1'b0;
  endtask

  task automatic set_wr(int x, int y, logic d);
    wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = d;
  endtask

  task automatic set_rd(int x, int y, logic d, logic oob);
    rd_req = 1'b1; rd_x = XW'(x); rd_y = YW'(y);
    q.push_back('{d, oob, cyc_n + 1});
  endtask

  task automatic wr(int x, int y, logic d);
    set_wr(x, y, d); tick(); wr_en = 1'b0;
  endtask

  task automatic rd(int x, int y, logic d, logic oob);
    set_rd(x, y, d, oob); tick(); rd_req = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int y = 0; y < int'(MH); y++)
      for (int x = 0; x < int'(MW); x++)
        rd(x, y, 1'b0, 1'b0);
  endtask

  // Count busy cycles at negedges; optionally hammer writes/reads/clear meanwhile
  task automatic wait_busy(output int n, input bit poke);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (poke) begin
        wr_en = 1'b1; wr_x = XW'(i % 64); wr_y = YW'(i % 16); wr_data = 1'b1;
        rd_req = 1'b1; rd_x = XW'(i % 64); rd_y = YW'(i % 16);
        clear_start = 1'b1;
      end
    end
    idle_in();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("pending_reads_drained", q.size(), 0);
  endtask

  initial begin
    int n;
    idle_in();
    wr_x = '0; wr_y = '0; wr_data = 1'b0; rd_x = '0; rd_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 1);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_rd_oob", int'(rd_oob), 0);
    check("reset_occ_count", int'(occ_count), 0);

    rst_n = 1'b1;
    wait_busy(n, 1'b0);
    check("busy_cycles_after_reset", n, int'(DEPTH));
    read_all_zero();
    check("occ_after_init", int'(occ_count), 0);

    // Set/reset counting and basic reads
    wr(5, 3, 1'b1); wr(6, 3, 1'b1); wr(5, 3, 1'b1);
    check("occ_after_three_writes", int'(occ_count), 2);
    rd(5, 3, 1'b1, 1'b0); rd(6, 3, 1'b1, 1'b0); rd(7, 3, 1'b0, 1'b0);
    wr(5, 3, 1'b0); wr(6, 3, 1'b0);
    check("occ_after_clears", int'(occ_count), 0);

    // Same cell write-first, then same word different bit
    set_wr(10, 2, 1'b1); set_rd(10, 2, 1'b1, 1'b0); tick(); idle_in();
    check("occ_after_same_cell", int'(occ_count), 1);
    set_wr(11, 2, 1'b1); set_rd(12, 2, 1'b0, 1'b0); tick(); idle_in();
    check("occ_after_same_word", int'(occ_count), 2);
    rd(11, 2, 1'b1, 1'b0);

    // Bounds
    rd(64, 0, 1'b1, 1'b1); rd(0, 16, 1'b1, 1'b1); rd(127, 31, 1'b1, 1'b1);
    rd(63, 15, 1'b0, 1'b0);
    wr(63, 16, 1'b1);
    check("occ_after_oob_write", int'(occ_count), 2);

    // Clear sweep racing a write and a read
    wr(0, 1, 1'b1); wr(1, 1, 1'b1); wr(2, 15, 1'b1); wr(63, 15, 1'b1); wr(32, 8, 1'b1);
    check("occ_before_clear", int'(occ_count), 7);
    clear_start = 1'b1; set_wr(0, 0, 1'b1); set_rd(10, 2, 1'b1, 1'b0);
    tick(); idle_in();
    check("occ_on_clear_start", int'(occ_count), 0);
    check("busy_after_clear_start", int'(busy), 1);
    wait_busy(n, 1'b1);
    check("busy_cycles_clear", n, int'(DEPTH));
    check("occ_after_sweep", int'(occ_count), 0);
    drain();
    read_all_zero();

    // Reset in the middle of a sweep
    wr(1, 1, 1'b1);
    check("occ_before_reset_test", int'(occ_count), 1);
    clear_start = 1'b1; tick(); idle_in();
    repeat (40) tick();
    #3 rst_n = 1'b0;
    #1;
    check("midclear_reset_busy", int'(busy), 1);
    check("midclear_reset_occ", int'(occ_count), 0);
    check("midclear_reset_rd_valid", int'(rd_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(n, 1'b0);
    check("busy_cycles_after_midclear_reset", n, int'(DEPTH));
    rd(1, 1, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
